vga_pixel_out: RTL and testbench

Display back end that consumes what the UI and scene address generators produce. It owns VGA 640×480@60 timing and publishes `h_cnt`/`v_cnt` to the address generators. It samples the returned sprite-ROM pixels, composites the UI overlay over the scene, and drives the VGA pins. It also owns a per-frame fade-out/fade-in sequencer that decides which game state the UI drawer is told to render.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing.sv | 82 ++++++++
 rtl/vga_pixel_out.sv | 144 ++++++++++++++
 tb/tb_vga_pixel_out.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster geometry, game-state codes, fade FSM states and the
// per-channel fade scaler for the VGA back end.
package vga_pkg;

  localparam int RGB_W   = 12;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  typedef enum logic [3:0] {
    GS_TITLE  = 4'd0,
    GS_MENU   = 4'd1,
    GS_PLAY   = 4'd2,
    GS_PAUSE  = 4'd3,
    GS_SHOP   = 4'd4,
    GS_SCORE  = 4'd5,
    GS_WIN    = 4'd6,
    GS_LOSE   = 4'd7,
    GS_FAIL   = 4'd8
  } game_state_e;

  typedef enum logic [1:0] {
    FADE_STEADY = 2'd0,
    FADE_OUT    = 2'd1,
    FADE_SWAP   = 2'd2,
    FADE_IN     = 2'd3
  } fade_state_e;

  // (c * level) >> 4 on a 9-bit product; level 16 leaves c unchanged.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] level);
    logic [8:0] prod;
    prod = {5'd0, c} * {4'd0, level};
    return prod[7:4];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v raster counters, registered sync decode and the
// frame_start pulse emitted when the counters wrap to (0,0).
module vga_timing import vga_pkg::*; #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = H_VIS,
  parameter int H_FRONT   = H_FP,
  parameter int H_SYNC_W  = H_SYNC,
  parameter int H_LINE    = H_TOTAL,
  parameter int V_VISIBLE = V_VIS,
  parameter int V_FRONT   = V_FP,
  parameter int V_SYNC_W  = V_SYNC,
  parameter int V_FRAME   = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       tick,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_hs_on;
  logic             w_vs_on;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h_last = (r_h == 10'(H_LINE - 1));
  assign w_v_last = (r_v == 10'(V_FRAME - 1));
  assign w_hs_on  = (r_h >= 10'(H_VISIBLE + H_FRONT)) && (r_h < 10'(H_VISIBLE + H_FRONT + H_SYNC_W));
  assign w_vs_on  = (r_v >= 10'(V_VISIBLE + V_FRONT)) && (r_v < 10'(V_VISIBLE + V_FRONT + V_SYNC_W));

  // Syncs use the pre-advance counts so they line up with the registered colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_div   <= '0;
        r_hsync <= ~w_hs_on;
        r_vsync <= ~w_vs_on;
        if (w_h_last) begin
          r_h           <= '0;
          r_v           <= w_v_last ? 10'd0 : r_v + 10'd1;
          r_frame_start <= w_v_last;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign h_cnt       = r_h;
  assign v_cnt       = r_v;
  assign tick        = w_tick;
  assign active      = (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: rtl/vga_pixel_out.sv
// VGA back end: overlay/scene compositing, fade scaling and the frame-stepped
// fade sequencer that decides which game state the address generators draw.
module vga_pixel_out import vga_pkg::*; #(
  parameter int          CLK_DIV          = 4,
  parameter int          FADE_STEP_FRAMES = 1,
  parameter logic [11:0] KEY_COLOR        = 12'h0F0,
  parameter int          H_VISIBLE        = H_VIS,
  parameter int          H_FRONT          = H_FP,
  parameter int          H_SYNC_W         = H_SYNC,
  parameter int          H_LINE           = H_TOTAL,
  parameter int          V_VISIBLE        = V_VIS,
  parameter int          V_FRONT          = V_FP,
  parameter int          V_SYNC_W         = V_SYNC,
  parameter int          V_FRAME          = V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       game_state,
  input  logic             overlay_obj,
  input  logic [RGB_W-1:0] overlay_pixel,
  input  logic [RGB_W-1:0] scene_pixel,
  output logic [9:0]       h_cnt,
  output logic [9:0]       v_cnt,
  output logic [3:0]       shown_state,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             frame_start,
  output logic             fading
);

  fade_state_e      r_state;
  fade_state_e      w_state_next;
  logic [4:0]       r_level;
  logic [4:0]       w_level_next;
  logic [3:0]       r_shown;
  logic [3:0]       w_shown_next;
  logic [3:0]       r_step;
  logic [3:0]       w_step_next;
  logic [RGB_W-1:0] r_rgb;
  logic [RGB_W-1:0] w_mix;
  logic             w_tick;
  logic             w_active;
  logic             w_step;

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC_W  (H_SYNC_W),
    .H_LINE    (H_LINE),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC_W  (V_SYNC_W),
    .V_FRAME   (V_FRAME)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .tick        (w_tick),
    .active      (w_active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always_comb begin
    w_mix = '0;
    if (w_active) begin
      w_mix = (overlay_obj && (overlay_pixel != KEY_COLOR)) ? overlay_pixel : scene_pixel;
    end
  end

  assign w_step = frame_start && (r_step == 4'(FADE_STEP_FRAMES - 1));

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_shown_next = r_shown;
    w_step_next  = r_step;
    case (r_state)
      FADE_STEADY: begin
        if (frame_start && (game_state != r_shown)) begin
          w_state_next = FADE_OUT;
          w_step_next  = '0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          w_step_next = w_step ? 4'd0 : r_step + 4'd1;
          if (w_step) begin
            w_level_next = r_level - 5'd1;
            if (r_level == 5'd1) w_state_next = FADE_SWAP;
          end
        end
      end
      FADE_SWAP: begin
        w_shown_next = game_state;
        w_step_next  = '0;
        w_state_next = FADE_IN;
      end
      FADE_IN: begin
        if (frame_start) begin
          w_step_next = w_step ? 4'd0 : r_step + 4'd1;
          if (w_step) begin
            w_level_next = r_level + 5'd1;
            if (r_level == LEVEL_MAX - 5'd1) w_state_next = FADE_STEADY;
          end
        end
      end
      default: w_state_next = FADE_STEADY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FADE_STEADY;
      r_level <= LEVEL_MAX;
      r_shown <= GS_TITLE;
      r_step  <= '0;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_next;
      r_level <= w_level_next;
      r_shown <= w_shown_next;
      r_step  <= w_step_next;
      if (w_tick) begin
        r_rgb <= {scale_chan(w_mix[11:8], r_level),
                  scale_chan(w_mix[7:4],  r_level),
                  scale_chan(w_mix[3:0],  r_level)};
      end
    end
  end

  assign shown_state = r_shown;
  assign fading      = (r_state != FADE_STEADY);
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];

endmodule

// File: tb/tb_vga_pixel_out.sv
// Randomised pixel stimulus against an arithmetic raster/fade reference on a
// shrunken raster so that many complete fades fit in a short run.
module tb_vga_pixel_out;
  import vga_pkg::*;

  localparam int          D   = 4;
  localparam int          FSF = 1;
  localparam logic [11:0] KEY = 12'h0F0;
  localparam int HV = 8, HF = 2, HS = 3, HT = 16;
  localparam int VV = 4, VF = 1, VS = 2, VT = 8;
  localparam int F  = D * HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  game_state = 4'd0;
  logic        overlay_obj = 1'b0;
  logic [11:0] overlay_pixel = 12'd0;
  logic [11:0] scene_pixel = 12'd0;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  shown_state, vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_start, fading;

  vga_pixel_out #(
    .CLK_DIV (D), .FADE_STEP_FRAMES (FSF), .KEY_COLOR (KEY),
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC_W (HS), .H_LINE (HT),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC_W (VS), .V_FRAME (VT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .game_state (game_state),
    .overlay_obj (overlay_obj), .overlay_pixel (overlay_pixel), .scene_pixel (scene_pixel),
    .h_cnt (h_cnt), .v_cnt (v_cnt), .shown_state (shown_state),
    .hsync (hsync), .vsync (vsync), .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .frame_start (frame_start), .fading (fading)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: clocks since reset, fade progress in steps (-1 = idle).
  int          c;
  int          m_pos, m_sub, m_swap_c, m_level;
  logic [3:0]  m_shown;
  logic [11:0] m_rgb;
  logic        m_hs, m_vs;
  logic        cur_obj;
  logic [11:0] cur_ov, cur_sc;
  logic        force_white = 1'b0;

  function automatic int scale(input int ch, input int lvl);
    return (ch * lvl) / 16;
  endfunction

  task automatic drive_pixel();
    cur_obj = force_white ? 1'b0 : 1'($urandom_range(0, 1));
    cur_ov  = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    cur_sc  = force_white ? 12'hFFF : 12'($urandom);
    overlay_obj   = cur_obj;
    overlay_pixel = cur_ov;
    scene_pixel   = cur_sc;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_h", h_cnt, 0);
    check("rst_v", v_cnt, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_hs", hsync, 1);
    check("rst_vs", vsync, 1);
    check("rst_fs", frame_start, 0);
    check("rst_fading", fading, 0);
    check("rst_shown", shown_state, 0);
    c = 0; m_pos = -1; m_sub = 0; m_swap_c = -1; m_level = 16;
    m_shown = 4'd0; m_rgb = 12'd0; m_hs = 1'b1; m_vs = 1'b1;
    drive_pixel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    int p, h, v;
    logic [11:0] col;
    @(posedge clk);
    #1;
    c++;
    if (c % D == 0) begin
      p = c / D - 1;
      h = p % HT;
      v = (p / HT) % VT;
      col = 12'd0;
      if (h < HV && v < VV) col = (cur_obj && cur_ov != KEY) ? cur_ov : cur_sc;
      m_rgb = {4'(scale(int'(col[11:8]), m_level)), 4'(scale(int'(col[7:4]), m_level)),
               4'(scale(int'(col[3:0]), m_level))};
      m_hs = !(h >= HV + HF && h < HV + HF + HS);
      m_vs = !(v >= VV + VF && v < VV + VF + VS);
    end
    if (c > 1 && (c - 1) % F == 0) begin
      if (m_pos < 0) begin
        if (game_state != m_shown) begin
          m_pos = 0;
          m_sub = 0;
        end
      end else begin
        m_sub++;
        if (m_sub == FSF) begin
          m_sub = 0;
          m_pos++;
          if (m_pos == 16) m_swap_c = c + 1;
          if (m_pos == 32) m_pos = -1;
        end
      end
    end
    if (c == m_swap_c) m_shown = game_state;
    m_level = (m_pos < 0) ? 16 : ((m_pos <= 16) ? 16 - m_pos : m_pos - 16);

    check("h_cnt", h_cnt, (c / D) % HT);
    check("v_cnt", v_cnt, (c / D / HT) % VT);
    check("frame_start", frame_start, (c % F == 0));
    check("fading", fading, (m_pos >= 0));
    check("shown_state", shown_state, m_shown);
    check("rgb", {vga_r, vga_g, vga_b}, m_rgb);
    check("hsync", hsync, m_hs);
    check("vsync", vsync, m_vs);
    if (c % D == 0) drive_pixel();
  endtask

  initial begin
    int hs_low, vs_low, fs_n;
    logic reached;
    #2;
    apply_reset();

    hs_low = 0; vs_low = 0; fs_n = 0;
    for (int i = 0; i < 2 * F; i++) begin
      step();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_n++;
    end
    check("hsync_low_clks", hs_low, 2 * VT * HS * D);
    check("vsync_low_clks", vs_low, 2 * VS * HT * D);
    check("frame_start_count", fs_n, 2);

    // Single fade 0 -> 2 with a white scene held while the level is 8.
    repeat (200) step();
    game_state = 4'd2;
    reached = 1'b0;
    for (int i = 0; i < 40 * F && !reached; i++) begin
      step();
      reached = (m_level == 8) && (m_pos < 16) && (m_pos >= 0);
    end
    check("reach_level8", reached, 1);
    force_white = 1'b1;
    repeat (F) step();
    force_white = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40 * F && !reached; i++) begin
      step();
      reached = (m_pos < 0);
    end
    check("fadeA_done", reached, 1);
    check("fadeA_shown", shown_state, 2);
    check("fadeA_fading", fading, 0);

    // 2 -> 4 then 6 during fade-out; 8 requested during fade-in.
    repeat (300) step();
    game_state = 4'd4;
    repeat (5 * F) step();
    game_state = 4'd6;
    reached = 1'b0;
    for (int i = 0; i < 40 * F && !reached; i++) begin
      step();
      reached = (m_pos == 20);
    end
    check("reach_fadein", reached, 1);
    check("fadeB_shown", shown_state, 6);
    game_state = 4'd8;
    reached = 1'b0;
    for (int i = 0; i < 60 * F && !reached; i++) begin
      step();
      reached = (m_shown == 4'd6) && (m_pos == 11);
    end
    check("reach_level5", reached, 1);

    // Asynchronous reset in the middle of the second fade-out.
    repeat (100) step();
    #2;
    apply_reset();
    repeat (F + 50) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
